// File: rtl/aes_pkg.sv
// Shared AES helpers: cipher direction, iterative MixColumns FSM states, GF(2^8) doubling.
package aes_pkg;

  localparam int unsigned OpW = 6;

  typedef enum logic [OpW-1:0] {
    CIPH_FWD = 6'b011001,
    CIPH_INV = 6'b100110
  } ciph_op_e;

  typedef enum logic [2:0] {
    MC_IDLE = 3'b001,
    MC_BUSY = 3'b010,
    MC_DONE = 3'b100
  } mixcol_iter_state_e;

  typedef logic [3:0][7:0] aes_col_t;

  function automatic logic [7:0] aes_mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] aes_mul4(input logic [7:0] b);
    return aes_mul2(aes_mul2(b));
  endfunction

endpackage

// File: rtl/aes_mix_single_column.sv
// Combinational MixColumns / InvMixColumns on one 4-byte column.
module aes_mix_single_column
  import aes_pkg::*;
(
  input  ciph_op_e op_i,
  input  aes_col_t col_i,
  output aes_col_t col_o
);

  aes_col_t   a;
  logic [7:0] u;
  logic [7:0] v;

  function automatic logic [7:0] fwd_row(input logic [7:0] a0, input logic [7:0] a1,
                                         input logic [7:0] a2, input logic [7:0] a3);
    return aes_mul2(a0) ^ aes_mul2(a1) ^ a1 ^ a2 ^ a3;
  endfunction

  // Inverse folds into the forward matrix after a cheap {05,00,04,00} pre-multiply.
  always_comb begin
    a = col_i;
    u = '0;
    v = '0;
    if (op_i == CIPH_INV) begin
      u    = aes_mul4(col_i[0] ^ col_i[2]);
      v    = aes_mul4(col_i[1] ^ col_i[3]);
      a[0] = col_i[0] ^ u;
      a[2] = col_i[2] ^ u;
      a[1] = col_i[1] ^ v;
      a[3] = col_i[3] ^ v;
    end
  end

  assign col_o[0] = fwd_row(a[0], a[1], a[2], a[3]);
  assign col_o[1] = fwd_row(a[1], a[2], a[3], a[0]);
  assign col_o[2] = fwd_row(a[2], a[3], a[0], a[1]);
  assign col_o[3] = fwd_row(a[3], a[0], a[1], a[2]);

endmodule

// File: rtl/aes_mix_columns_iter.sv
// Iterative MixColumns engine: mixes ColsPerCycle columns of the held state per cycle,
// with valid/ready handshakes on both sides.
module aes_mix_columns_iter
  import aes_pkg::*;
#(
  parameter int unsigned NumCols      = 4,
  parameter int unsigned ColsPerCycle = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic                          in_valid_i,
  output logic                          in_ready_o,
  input  ciph_op_e                      op_i,
  input  logic [NumCols-1:0][3:0][7:0]  data_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [NumCols-1:0][3:0][7:0]  data_o,
  output logic                          err_o
);

  localparam int unsigned NumGroups = NumCols / ColsPerCycle;
  localparam int unsigned GrpW      = (NumGroups > 1) ? $clog2(NumGroups) : 1;
  localparam logic [GrpW-1:0] LastGrp = GrpW'(NumGroups - 1);

  if (NumCols < 1 || NumCols > 8) begin : g_bad_num_cols
    $error("aes_mix_columns_iter: NumCols must be in 1..8");
  end
  if (NumCols % ColsPerCycle != 0) begin : g_bad_cols_per_cycle
    $error("aes_mix_columns_iter: NumCols must be a multiple of ColsPerCycle");
  end

  mixcol_iter_state_e          state_q, state_d;
  logic [NumCols-1:0][3:0][7:0] data_q, data_d, data_mixed;
  ciph_op_e                    op_q, op_d;
  logic [GrpW-1:0]             grp_q, grp_d;
  logic                        err_q, err_d;
  logic                        accept;

  aes_col_t mix_in  [ColsPerCycle];
  aes_col_t mix_out [ColsPerCycle];

  // Select the current column group into the mixer lanes.
  always_comb begin
    for (int k = 0; k < ColsPerCycle; k++) begin
      mix_in[k] = '0;
      for (int g = 0; g < NumGroups; g++) begin
        if (grp_q == GrpW'(g)) mix_in[k] = data_q[g*ColsPerCycle + k];
      end
    end
  end

  for (genvar k = 0; k < ColsPerCycle; k++) begin : g_mix
    aes_mix_single_column u_mix (
      .op_i  (op_q),
      .col_i (mix_in[k]),
      .col_o (mix_out[k])
    );
  end

  // Write mixed lanes back; columns outside the current group keep their value.
  always_comb begin
    data_mixed = data_q;
    for (int c = 0; c < NumCols; c++) begin
      if (grp_q == GrpW'(c / ColsPerCycle)) data_mixed[c] = mix_out[c % ColsPerCycle];
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    op_d       = op_q;
    grp_d      = grp_q;
    err_d      = err_q;
    in_ready_o = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      MC_IDLE: begin
        in_ready_o = 1'b1;
        accept     = in_valid_i;
      end
      MC_BUSY: begin
        data_d = data_mixed;
        if (grp_q == LastGrp) begin
          grp_d   = '0;
          state_d = MC_DONE;
        end else begin
          grp_d = grp_q + GrpW'(1);
        end
      end
      MC_DONE: begin
        if (out_ready_i) begin
          in_ready_o = 1'b1;
          if (in_valid_i) begin
            accept = 1'b1;
          end else begin
            state_d = MC_IDLE;
            data_d  = '0;
            err_d   = 1'b0;
          end
        end
      end
      default: state_d = MC_IDLE;
    endcase
    // Invalid directions still run, as the forward transform, but are flagged.
    if (accept) begin
      data_d  = data_i;
      op_d    = op_i;
      grp_d   = '0;
      err_d   = !(op_i inside {CIPH_FWD, CIPH_INV});
      state_d = MC_BUSY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q <= MC_IDLE;
      data_q  <= '0;
      op_q    <= CIPH_FWD;
      grp_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      op_q    <= op_d;
      grp_q   <= grp_d;
      err_q   <= err_d;
    end
  end

  // Intermediate state never leaves the block.
  assign out_valid_o = (state_q == MC_DONE);
  assign data_o      = out_valid_o ? data_q : '0;
  assign err_o       = out_valid_o & err_q;

endmodule

// File: tb/tb_aes_mix_columns_iter.sv
// Bench for aes_mix_columns_iter: CPC=1/2/4 builds against a GF(2^8) matrix reference model.
module tb_aes_mix_columns_iter;
  import aes_pkg::*;

  typedef logic [3:0][3:0][7:0] st_t;

  logic     clk = 1'b0;
  logic     rst;
  logic     clr;
  ciph_op_e op;
  st_t      din;
  logic     inv  [3];
  logic     ordy [3];
  logic     irdy [3];
  logic     ov   [3];
  logic     err  [3];
  st_t      dout [3];
  int       ncmp  = 0;
  int       nfail = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    aes_mix_columns_iter #(.NumCols(4), .ColsPerCycle(1 << i)) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .clear_i     (clr),
      .in_valid_i  (inv[i]),
      .in_ready_o  (irdy[i]),
      .op_i        (op),
      .data_i      (din),
      .out_valid_o (ov[i]),
      .out_ready_i (ordy[i]),
      .data_o      (dout[i]),
      .err_o       (err[i])
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= 16'(a) << i;
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h011b << (i - 8);
    return p[7:0];
  endfunction

  // Circulant matrix product: b_r = sum_j coef[j] * a_{r+j}.
  function automatic st_t model(input logic inverse, input st_t s);
    logic [7:0] coef [4];
    logic [7:0] acc;
    st_t        res;
    if (inverse) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else         coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) acc ^= gmul(coef[j], s[c][(r + j) % 4]);
        res[c][r] = acc;
      end
    end
    return res;
  endfunction

  // Literal written column 0 row 0 first.
  function automatic st_t from_rows(input logic [127:0] v);
    st_t s;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[c][r] = v[127 - 8*(4*c + r) -: 8];
    return s;
  endfunction

  function automatic st_t rnd_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_result(input int i, input st_t exp, input logic exp_err, input string tag);
    int lat;
    lat = 0;
    while (!ov[i] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 128'(lat), 128'(4 >> i));
    chk({tag, "_data"}, dout[i], exp);
    chk({tag, "_err"}, 128'(err[i]), 128'(exp_err));
    if (ordy[i]) begin
      @(posedge clk); #1;
      chk({tag, "_post_valid"}, 128'(ov[i]), 128'(0));
      chk({tag, "_post_data"}, dout[i], 128'(0));
      chk({tag, "_post_err"}, 128'(err[i]), 128'(0));
    end
  endtask

  task automatic run_block(input int i, input ciph_op_e o, input st_t d, input st_t exp,
                           input logic exp_err, input string tag);
    op  = o;
    din = d;
    chk({tag, "_in_ready"}, 128'(irdy[i]), 128'(1));
    inv[i] = 1'b1;
    @(posedge clk); #1;
    inv[i] = 1'b0;
    op     = ($urandom_range(0, 1) == 1) ? CIPH_INV : CIPH_FWD;
    din    = rnd_state();
    wait_result(i, exp, exp_err, tag);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    st_t vin, vout, da, dj, dc, d;
    logic inverse;
    logic seen;

    vin  = from_rows(128'hdb135345_f20a225c_01010101_d4bf5d30);
    vout = from_rows(128'h8e4da1bc_9fdc589d_01010101_046681e5);

    rst = 1'b1; clr = 1'b0; op = CIPH_FWD; din = '0;
    for (int i = 0; i < 3; i++) begin inv[i] = 1'b0; ordy[i] = 1'b1; end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_in_ready", 128'(irdy[i]), 128'(1));
      chk("rst_out_valid", 128'(ov[i]), 128'(0));
      chk("rst_data", dout[i], 128'(0));
      chk("rst_err", 128'(err[i]), 128'(0));
    end
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 3; i++) begin
      run_block(i, CIPH_FWD, vin, vout, 1'b0, $sformatf("vec_fwd_cpc%0d", 1 << i));
      run_block(i, CIPH_INV, vout, vin, 1'b0, $sformatf("vec_inv_cpc%0d", 1 << i));
    end

    for (int n = 0; n < 15; n++) begin
      for (int i = 0; i < 3; i++) begin
        d       = rnd_state();
        inverse = 1'($urandom_range(0, 1));
        run_block(i, inverse ? CIPH_INV : CIPH_FWD, d, model(inverse, d), 1'b0,
                  $sformatf("rnd%0d_cpc%0d", n, 1 << i));
      end
    end

    // Backpressure: result held, new input ignored, then back-to-back accept.
    ordy[0] = 1'b0;
    da = rnd_state();
    run_block(0, CIPH_FWD, da, model(1'b0, da), 1'b0, "bp_a");
    dj = rnd_state();
    inv[0] = 1'b1; din = dj; op = CIPH_INV;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp_hold_data", dout[0], model(1'b0, da));
      chk("bp_hold_in_ready", 128'(irdy[0]), 128'(0));
      chk("bp_hold_valid", 128'(ov[0]), 128'(1));
    end
    dc = rnd_state();
    din = dc; op = CIPH_FWD; ordy[0] = 1'b1;
    #1;
    chk("bp_b2b_in_ready", 128'(irdy[0]), 128'(1));
    @(posedge clk); #1;
    inv[0] = 1'b0;
    din = rnd_state();
    wait_result(0, model(1'b0, dc), 1'b0, "bp_c");

    // Clear on the second busy cycle discards the block.
    din = rnd_state(); op = CIPH_FWD; inv[0] = 1'b1;
    @(posedge clk); #1;
    inv[0] = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_in_ready", 128'(irdy[0]), 128'(1));
    chk("clr_valid", 128'(ov[0]), 128'(0));
    chk("clr_data", dout[0], 128'(0));
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ov[0]) seen = 1'b1;
    end
    chk("clr_never_valid", 128'(seen), 128'(0));

    d = rnd_state();
    run_block(0, ciph_op_e'(6'b000000), d, model(1'b0, d), 1'b1, "bad_op");

    // Reset in the middle of a block.
    din = rnd_state(); op = CIPH_INV; inv[0] = 1'b1;
    @(posedge clk); #1;
    inv[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", 128'(irdy[0]), 128'(1));
    chk("midrst_valid", 128'(ov[0]), 128'(0));
    chk("midrst_data", dout[0], 128'(0));
    chk("midrst_err", 128'(err[0]), 128'(0));
    d = rnd_state();
    run_block(0, CIPH_INV, d, model(1'b1, d), 1'b0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
